// File: rtl/acq_seq_pkg.sv
// Shared definitions for the acquisition stream sequencer: FSM encoding,
// default geometry and a width helper.
package acq_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARM         = 3'd1,
    ST_WAIT_SAMPLE = 3'd2,
    ST_BURST       = 3'd3,
    ST_FINAL_WAIT  = 3'd4
  } state_t;

  localparam int DEF_WORDS_PER_SAMPLE = 16;
  localparam int DEF_PKT_WORDS        = 16384;
  localparam int DEF_CNT_W            = 32;
  localparam int DEF_DROP_W           = 16;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/acq_stream_sequencer.sv
// Turns ADC sample strobes into fixed-size AXIS bursts framed into DMA
// packets, gated on FIFO drain at arm time and counting dropped samples.
module acq_stream_sequencer
  import acq_seq_pkg::*;
#(
  parameter int WORDS_PER_SAMPLE = DEF_WORDS_PER_SAMPLE,
  parameter int PKT_WORDS        = DEF_PKT_WORDS,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int DROP_W           = DEF_DROP_W
) (
  input  logic                                data_clk,
  input  logic                                user_rstn,
  input  logic                                dma_ena,
  input  logic                                new_sample,
  input  logic                                fifo_prog_empty,
  input  logic                                fifo_prog_full,
  input  logic                                m_tready,
  output logic                                m_tvalid,
  output logic                                m_tlast,
  output logic [$clog2(WORDS_PER_SAMPLE)-1:0] chan_sel,
  output logic                                busy,
  output logic [CNT_W-1:0]                    sample_cnt,
  output logic [CNT_W-1:0]                    pkt_cnt,
  output logic [DROP_W-1:0]                   drop_cnt,
  output logic                                overrun
);

  localparam int SEL_W  = $clog2(WORDS_PER_SAMPLE);
  localparam int WORD_W = idx_width(PKT_WORDS);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(WORDS_PER_SAMPLE - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(PKT_WORDS - 1);

  // Handshake: a beat transfers on a cycle where m_tvalid and m_tready are
  // both high; m_tvalid and chan_sel never change while waiting for m_tready.

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] pkt_word;
  logic [WORD_W-1:0] pkt_word_inc;
  logic              final_burst;
  logic              beat;
  logic              last_beat;
  logic              accept;
  logic              drop;
  logic              arm_clr;

  // Event decode, all from registered state and synchronous inputs.
  always_comb begin
    beat         = (state == ST_BURST) && m_tready;
    last_beat    = beat && (chan_sel == SEL_LAST);
    pkt_word_inc = (pkt_word == WORD_LAST) ? '0 : pkt_word + WORD_W'(1);
    arm_clr      = (state == ST_IDLE) && dma_ena;
    accept       = new_sample &&
                   (((state == ST_WAIT_SAMPLE) && dma_ena && !fifo_prog_full) ||
                    (state == ST_FINAL_WAIT));
    drop         = new_sample &&
                   (((state == ST_WAIT_SAMPLE) && dma_ena && fifo_prog_full) ||
                    (state == ST_BURST));
  end

  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dma_ena) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (!dma_ena)            state_nxt = ST_IDLE;
        else if (fifo_prog_empty) state_nxt = ST_WAIT_SAMPLE;
      end
      ST_WAIT_SAMPLE: begin
        if (!dma_ena)    state_nxt = (pkt_word == '0) ? ST_IDLE : ST_FINAL_WAIT;
        else if (accept) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        if (last_beat) begin
          if (final_burst)                          state_nxt = ST_IDLE;
          else if (!dma_ena && pkt_word_inc != '0)  state_nxt = ST_FINAL_WAIT;
          else                                      state_nxt = ST_WAIT_SAMPLE;
        end
      end
      ST_FINAL_WAIT: begin
        if (accept)       state_nxt = ST_BURST;
        else if (dma_ena) state_nxt = ST_WAIT_SAMPLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_tvalid = (state == ST_BURST);
    m_tlast  = (state == ST_BURST) &&
               ((pkt_word == WORD_LAST) || (final_burst && (chan_sel == SEL_LAST)));
    busy     = (state != ST_IDLE);
  end

  // Beat position within the burst and the packet.
  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      chan_sel    <= '0;
      pkt_word    <= '0;
      final_burst <= 1'b0;
    end else if (arm_clr) begin
      chan_sel    <= '0;
      pkt_word    <= '0;
      final_burst <= 1'b0;
    end else if (accept) begin
      chan_sel    <= '0;
      final_burst <= (state == ST_FINAL_WAIT);
    end else if (beat) begin
      chan_sel <= chan_sel + SEL_W'(1);
      // A closing burst ends the packet even when it is short.
      pkt_word <= (last_beat && final_burst) ? '0 : pkt_word_inc;
    end
  end

  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      sample_cnt <= '0;
      pkt_cnt    <= '0;
      overrun    <= 1'b0;
    end else if (arm_clr) begin
      sample_cnt <= '0;
      pkt_cnt    <= '0;
      overrun    <= 1'b0;
    end else begin
      if (accept)          sample_cnt <= sample_cnt + CNT_W'(1);
      if (beat && m_tlast) pkt_cnt    <= pkt_cnt + CNT_W'(1);
      if (drop)            overrun    <= 1'b1;
    end
  end

  sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk  (data_clk),
    .rstn (user_rstn),
    .inc  (drop),
    .clr  (arm_clr),
    .q    (drop_cnt)
  );

endmodule

// File: tb/tb_acq_stream_sequencer.sv
// Bench for acq_stream_sequencer: directed scenarios plus random traffic,
// checked against a burst-level reference model and expected-beat queue.
`timescale 1ns/1ps
module tb_acq_stream_sequencer;

  localparam int WPS    = 4;
  localparam int PKT    = 8;
  localparam int CNT_W  = 32;
  localparam int DROP_W = 4;
  localparam int SEL_W  = 2;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic data_clk = 1'b0;
  logic user_rstn = 1'b0;
  logic dma_ena = 1'b0;
  logic new_sample = 1'b0;
  logic fifo_prog_empty = 1'b0;
  logic fifo_prog_full = 1'b0;
  logic m_tready = 1'b0;
  logic m_tvalid;
  logic m_tlast;
  logic [SEL_W-1:0] chan_sel;
  logic busy;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] pkt_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic overrun;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 data_clk = ~data_clk;

  acq_stream_sequencer #(
    .WORDS_PER_SAMPLE (WPS),
    .PKT_WORDS        (PKT),
    .CNT_W            (CNT_W),
    .DROP_W           (DROP_W)
  ) dut (
    .data_clk        (data_clk),
    .user_rstn       (user_rstn),
    .dma_ena         (dma_ena),
    .new_sample      (new_sample),
    .fifo_prog_empty (fifo_prog_empty),
    .fifo_prog_full  (fifo_prog_full),
    .m_tready        (m_tready),
    .m_tvalid        (m_tvalid),
    .m_tlast         (m_tlast),
    .chan_sel        (chan_sel),
    .busy            (busy),
    .sample_cnt      (sample_cnt),
    .pkt_cnt         (pkt_cnt),
    .drop_cnt        (drop_cnt),
    .overrun         (overrun)
  );

  // ---------------- reference model ----------------
  // mode: acquisition off, waiting for FIFO drain, running, closing a packet
  localparam int M_OFF = 0, M_DRAIN = 1, M_RUN = 2, M_CLOSE = 3;
  int          mode;
  int          beats_left;
  int          pkt_words;
  bit          fin;
  int unsigned m_samples;
  int unsigned m_pkts;
  int          m_drops;
  bit          m_overrun;
  logic [SEL_W:0] exp_q[$];   // {tlast, chan_sel} per expected beat

  function automatic void model_reset();
    mode = M_OFF; beats_left = 0; pkt_words = 0; fin = 0;
    m_samples = 0; m_pkts = 0; m_drops = 0; m_overrun = 0;
    exp_q.delete();
  endfunction

  function automatic void note_drop();
    if (m_drops < DROP_MAX) m_drops++;
    m_overrun = 1;
  endfunction

  function automatic void start_burst(input bit closing);
    logic [SEL_W:0] e;
    fin = closing;
    m_samples++;
    beats_left = WPS;
    for (int k = 0; k < WPS; k++) begin
      e[SEL_W-1:0] = SEL_W'(k);
      e[SEL_W] = (((pkt_words + k) % PKT) == PKT - 1) || (closing && k == WPS - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void model_update(input bit hs);
    logic [SEL_W:0] e;
    if (beats_left > 0) begin
      if (new_sample) note_drop();
      if (hs) begin
        e = exp_q.pop_front();
        if (e[SEL_W]) m_pkts++;
        pkt_words = (pkt_words + 1) % PKT;
        beats_left--;
        if (beats_left == 0) begin
          if (fin) begin
            pkt_words = 0;
            mode = M_OFF;
          end else if (!dma_ena && pkt_words != 0) begin
            mode = M_CLOSE;
          end
        end
      end
    end else begin
      case (mode)
        M_OFF: if (dma_ena) begin
          model_reset();
          mode = M_DRAIN;
        end
        M_DRAIN: begin
          if (!dma_ena) mode = M_OFF;
          else if (fifo_prog_empty) mode = M_RUN;
        end
        M_RUN: begin
          if (!dma_ena) mode = (pkt_words == 0) ? M_OFF : M_CLOSE;
          else if (new_sample) begin
            if (fifo_prog_full) note_drop();
            else start_burst(1'b0);
          end
        end
        default: begin
          if (new_sample) start_burst(1'b1);
          else if (dma_ena) mode = M_RUN;
        end
      endcase
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare outputs for the current cycle, then advance model and clock.
  task automatic step();
    bit hs;
    check("tvalid", m_tvalid, beats_left > 0);
    check("busy", busy, (mode != M_OFF) || (beats_left > 0));
    check("sample_cnt", sample_cnt, m_samples);
    check("pkt_cnt", pkt_cnt, m_pkts);
    check("drop_cnt", drop_cnt, m_drops);
    check("overrun", overrun, m_overrun);
    if (beats_left > 0) check("beat", {m_tlast, chan_sel}, exp_q[0]);
    hs = (beats_left > 0) && m_tready;
    model_update(hs);
    @(posedge data_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe();
    new_sample = 1'b1;
    step();
    new_sample = 1'b0;
  endtask

  task automatic do_reset();
    dma_ena = 0; new_sample = 0; fifo_prog_empty = 0; fifo_prog_full = 0; m_tready = 0;
    user_rstn = 1'b0;
    model_reset();
    @(posedge data_clk);
    @(posedge data_clk);
    #1;
    user_rstn = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_chan_sel", chan_sel, 0);

    // T1: two bursts fill exactly one packet
    dma_ena = 1; fifo_prog_empty = 1; m_tready = 1;
    steps(3);
    strobe(); steps(6);
    strobe(); steps(6);
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_sample_cnt", sample_cnt, 2);

    // T2: alternate tready while two bursts stream out
    for (int b = 0; b < 2; b++) begin
      strobe();
      for (int i = 0; i < 10; i++) begin
        m_tready = ~m_tready;
        step();
      end
    end
    m_tready = 1; steps(4);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // T3: strobes faster than bursts, then FIFO full
    for (int i = 0; i < 8; i++) begin
      strobe(); steps(2);
    end
    steps(6);
    fifo_prog_full = 1;
    strobe(); steps(2); strobe(); steps(2);
    fifo_prog_full = 0;
    check("t3_overrun", overrun, 1);

    // T4: stop after one burst of a packet, closing burst completes it
    do_reset();
    dma_ena = 1; fifo_prog_empty = 1; m_tready = 1;
    steps(2);
    strobe(); steps(6);
    dma_ena = 0; steps(3);
    check("t4_busy_closing", busy, 1);
    strobe(); steps(6);
    check("t4_busy_done", busy, 0);
    check("t4_pkt_cnt", pkt_cnt, 1);
    // stop on a packet boundary returns straight to idle
    dma_ena = 1; steps(2);
    strobe(); steps(6); strobe(); steps(6);
    dma_ena = 0; steps(3);
    check("t4_idle_direct", busy, 0);
    check("t4_pkt_cnt2", pkt_cnt, 1);

    // T5: no drain, no start
    do_reset();
    dma_ena = 1; fifo_prog_empty = 0; m_tready = 1;
    for (int i = 0; i < 10; i++) begin
      strobe(); steps(4);
    end
    check("t5_drop_cnt", drop_cnt, 0);
    check("t5_sample_cnt", sample_cnt, 0);
    fifo_prog_empty = 1; steps(1);
    strobe(); steps(6);
    check("t5_sample_cnt2", sample_cnt, 1);

    // T6: async reset in the middle of a burst
    do_reset();
    dma_ena = 1; fifo_prog_empty = 1; m_tready = 1;
    steps(2);
    strobe(); step();
    #2 user_rstn = 1'b0;
    #1;
    check("t6_rst_tvalid", m_tvalid, 0);
    check("t6_rst_chan_sel", chan_sel, 0);
    check("t6_rst_sample_cnt", sample_cnt, 0);
    check("t6_rst_busy", busy, 0);
    model_reset();
    dma_ena = 0; m_tready = 0;
    @(posedge data_clk);
    #1;
    user_rstn = 1'b1;
    dma_ena = 1; fifo_prog_full = 1; m_tready = 1;
    steps(2);
    new_sample = 1; steps(DROP_MAX + 5); new_sample = 0;
    check("t6_drop_sat", drop_cnt, DROP_MAX);
    fifo_prog_full = 0;

    // Random traffic
    do_reset();
    dma_ena = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) dma_ena = ~dma_ena;
      fifo_prog_empty = ($urandom_range(0, 3) != 0);
      fifo_prog_full  = ($urandom_range(0, 9) == 0);
      new_sample      = ($urandom_range(0, 5) == 0);
      m_tready        = ($urandom_range(0, 3) != 0);
      step();
    end
    new_sample = 0; m_tready = 1;
    steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
